tag_free_list: RTL
==================

Name: tag_free_list

Overview:
- Circular FIFO of free reservation-station tags, directly upstream of the register status table.
- On dispatch it supplies the 6-bit tag that the dispatch logic writes, with valid bit set, into the destination register's status entry.
- Tags come back when their result is broadcast on the CDB (cdb_valid/cdb_tag), so the free list and the register status table see the same broadcast.
- Pure storage and pointer logic; no renaming decisions are made here.

Parameters:
- TAG_WIDTH, 6, width of a tag; matches the register status table tag field.
- DEPTH, 64, number of tags in circulation; 2 <= DEPTH <= 2^TAG_WIDTH; need not be a power of 2.
- PTR_WIDTH, 6, pointer width; must satisfy 2^PTR_WIDTH >= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- alloc_req  input  1  dispatch consumes the head tag this cycle.
- alloc_tag  output  TAG_WIDTH  current head tag; meaningful only when alloc_valid=1.
- alloc_valid  output  1  free list non-empty (count != 0).
- cdb_valid  input  1  CDB broadcast valid; the tag is returned to the list.
- cdb_tag  input  TAG_WIDTH  tag being returned.
- free_count  output  PTR_WIDTH+1  number of free tags held.
- full  output  1  free_count == DEPTH.

Behaviour:
- Storage: DEPTH x TAG_WIDTH register array, rd_ptr, wr_ptr, count; all flops on async reset.
- Reset value: slot i holds tag i for i = 0..DEPTH-1.
- Reset outputs: rd_ptr=0, wr_ptr=0, free_count=DEPTH, full=1, alloc_valid=1, alloc_tag=0.
- alloc_tag = mem[rd_ptr], combinational from registered state; no combinational path from any input to any output.
- Pop: alloc_req & alloc_valid.
  - rd_ptr advances at the clock edge; the next tag appears the following cycle.
  - alloc_req while alloc_valid=0 is ignored: no pointer or count change.
- Push: cdb_valid & ~full.
  - mem[wr_ptr] <= cdb_tag; wr_ptr advances.
  - cdb_valid while full is dropped; state is unchanged.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0 on advance. Explicit compare, not a natural binary roll-over.
- free_count: +1 on push only, -1 on pop only, unchanged when both occur or neither occurs.
- Simultaneous pop and push when non-empty and not full: both take effect; count unchanged.
- Push while empty: the tag is written; alloc_valid rises the next cycle. There is no same-cycle bypass.
- Pop while full with a simultaneous cdb_valid: the pop occurs and the push is dropped, because full is evaluated before the edge.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to the reset image. In-flight tags are forgotten.
- Tag uniqueness is guaranteed by the caller. Each issued tag returns exactly once; no duplicate check is performed in the base build.

Optional Feature:
- Macro: TAG_FREE_LIST_ERR_EN.
- Defined: adds output err (1 bit, reset 0), a sticky flag.
  - Set on an alloc_req while empty.
  - Set on a cdb_valid while full.
  - Set on a push whose cdb_tag >= DEPTH; that push is also dropped.
  - Cleared only by reset.
- Not defined: no err port exists; out-of-range tags are stored as given; the other illegal events are silently ignored as described above.

Test Plan:
- Release reset, hold alloc_req=1 for 64 cycles -> alloc_tag sequence 0,1,...,63; alloc_valid falls after the 64th pop; free_count=0.
- From empty, cdb_valid with cdb_tag=5 -> next cycle alloc_valid=1, alloc_tag=5, free_count=1; the same-cycle alloc_req is ignored.
- Empty list, push 7 then 3 in consecutive cycles -> pops return 7 then 3 (FIFO order); free_count returns to 0.
- free_count=10, alloc_req and cdb_valid (tag 9) held together for 20 cycles -> free_count stays 10; 9 is popped in order behind the earlier entries.
- DEPTH=48: pop 48 and push 48 repeatedly across wrap -> pointers go 47->0; order is preserved; full=1 after all tags are returned.
- Reset asserted mid-stream with free_count=12 -> outputs immediately show free_count=64, full=1, alloc_tag=0.
  - With TAG_FREE_LIST_ERR_EN, a cdb_valid while full sets err=1, and err holds until reset.

Source files
------------

// File: rtl/tag_free_list.sv
// Circular FIFO of free reservation-station tags feeding dispatch; tags return on CDB broadcast.
// Optional sticky illegal-event flag 'err' enabled by defining TAG_FREE_LIST_ERR_EN.
module tag_free_list #(
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PTR_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 alloc_valid,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  output logic [PTR_WIDTH:0]   free_count,
  output logic                 full
`ifdef TAG_FREE_LIST_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [TAG_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 empty;
  logic                 pop;
  logic                 push;

  // Wrap by explicit compare so non-power-of-2 depths circulate correctly.
  function automatic logic [PTR_WIDTH-1:0] advance(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign alloc_valid = ~empty;
  assign alloc_tag   = mem_q[rd_ptr_q];
  assign free_count  = count_q;
  assign pop         = alloc_req & ~empty;

`ifdef TAG_FREE_LIST_ERR_EN
  logic tag_in_range;
  logic err_q, err_d;

  generate
    if (DEPTH < (1 << TAG_WIDTH)) begin : g_range_chk
      assign tag_in_range = (32'(cdb_tag) < DEPTH);
    end else begin : g_no_range_chk
      assign tag_in_range = 1'b1;
    end
  endgenerate

  assign push = cdb_valid & ~full & tag_in_range;
  assign err  = err_q;

  always_comb begin
    err_d = err_q | (alloc_req & empty) | (cdb_valid & (full | ~tag_in_range));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign push = cdb_valid & ~full;
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = advance(rd_ptr_q);
    if (push) wr_ptr_d = advance(wr_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (PTR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= FULL_CNT;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= TAG_WIDTH'(i);
    end else if (push) begin
      mem_q[wr_ptr_q] <= cdb_tag;
    end
  end

endmodule
